// File: rtl/alu_pkg.sv
// Shared types for the 4-bit ALU datapath.
// Provides the result width and the packed result entry used by the ALU
// register stage and by the result FIFO.
package alu_pkg;

    localparam int ALU_W = 4;

    typedef struct packed {
        logic             zero;
        logic             cout;
        logic [ALU_W-1:0] f;
    } alu_result_t;

    // The zero flag is derived from f, not supplied by the ALU.
    function automatic alu_result_t make_result(input logic [ALU_W-1:0] f,
                                                input logic             cout);
        alu_result_t r;
        r.zero = (f == '0);
        r.cout = cout;
        r.f    = f;
        return r;
    endfunction

endpackage

// File: rtl/alu_fifo_mem.sv
// Result storage for alu_result_fifo_4b.
// One synchronous write port, one asynchronous read port. No reset:
// contents are only ever read when the owning FIFO marks them valid.
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : entry to write
//   raddr_i  : read address
//   rdata_o  : entry at raddr_i (combinational)
module alu_fifo_mem
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  alu_result_t       wdata_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output alu_result_t       rdata_o
);

    alu_result_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_result_fifo_4b.sv
// Result FIFO downstream of the registered 4-bit ALU output stage.
// Captures {cout, f} on in_valid, stores {zero, cout, f} in order and
// hands entries to a consumer over valid/ready. Sticky overflow records
// any result dropped while full.
//   clk, reset_n         : clock, synchronous active-low reset
//   flush                : clear contents and overflow
//   in_valid/in_f/in_cout: producer side; in_ready = !full
//   out_valid/out_f/out_cout/out_zero, out_ready : consumer side
//   count/full/empty     : occupancy
//   overflow             : sticky drop indicator
module alu_result_fifo_4b
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [ALU_W-1:0] in_f,
    input  logic             in_cout,
    output logic             in_ready,
    output logic             out_valid,
    output logic [ALU_W-1:0] out_f,
    output logic             out_cout,
    output logic             out_zero,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic        push, pop, mem_we;
    alu_result_t head;

    // count is the only full/empty source, so equal pointers are never ambiguous.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    assign in_ready  = !full;
    assign out_valid = !empty;

    // Full blocks push even if a pop happens the same cycle; empty blocks
    // pop even if a push arrives, so neither pass-through nor fall-through.
    assign push = in_valid && !full;
    assign pop  = out_valid && out_ready;

    assign mem_we = push && !flush && reset_n;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
            if (in_valid && full) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    alu_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (make_result(in_f, in_cout)),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // Head data is gated so an empty FIFO never shows stale memory.
    assign out_f    = empty ? '0   : head.f;
    assign out_cout = empty ? 1'b0 : head.cout;
    assign out_zero = empty ? 1'b0 : head.zero;

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
